// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch and the MEM stage.
// Data wins ties until a streak of MAX_STREAK data grants forces a waiting fetch through.
module mem_port_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              read_mem,
    output logic              write_mem,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

    owner_t            r_owner, w_owner_nxt;
    logic [3:0]        r_streak, w_streak_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    // Grants are gated by reset so nothing reaches the memory while it is held.
    always_comb begin
        if_gnt       = reset & if_req & (~d_req | (r_streak == 4'(MAX_STREAK)));
        d_gnt        = reset & d_req & ~if_gnt;
        mem_addr     = if_gnt ? if_addr : d_gnt ? d_addr : r_addr;
        mem_wdata    = d_gnt ? d_wdata : r_wdata;
        read_mem     = if_gnt | (d_gnt & ~d_we);
        write_mem    = d_gnt & d_we;
        w_streak_nxt = (d_gnt & if_req) ? r_streak + 4'd1 : 4'd0;
        w_owner_nxt  = if_gnt ? OWN_IF : (d_gnt & ~d_we) ? OWN_D : OWN_NONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner  <= OWN_NONE;
            r_streak <= 4'd0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            r_owner  <= w_owner_nxt;
            r_streak <= w_streak_nxt;
            r_addr   <= mem_addr;
            r_wdata  <= mem_wdata;
        end
    end

    assign if_rvalid = (r_owner == OWN_IF);
    assign d_rvalid  = (r_owner == OWN_D);
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus against a behavioural arbitration/memory model,
// plus literal expectations for the named scenarios.
module tb_mem_port_arbiter;
    localparam int AW = 11, DW = 32, MS = 4;

    logic          clk = 0, reset = 0;
    logic          if_req = 0, d_req = 0, d_we = 0;
    logic [AW-1:0] if_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
    logic          if_gnt, if_rvalid, d_gnt, d_rvalid, read_mem, write_mem;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    int checks = 0, errors = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_STREAK(MS)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .read_mem(read_mem), .write_mem(write_mem),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Bench-side synchronous memory feeding the DUT.
    logic [DW-1:0] mem [2**AW];
    always @(posedge clk) begin
        if (read_mem) mem_rdata <= mem[mem_addr];
        if (write_mem) mem[mem_addr] <= mem_wdata;
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who should win, what the memory sees, what returns a cycle later.
    logic [DW-1:0] mdl_mem [2**AW];
    int            m_streak = 0;
    logic [AW-1:0] m_last_addr = '0;
    logic [DW-1:0] m_last_wdata = '0, m_pend_data = '0;
    bit            m_pend_if = 0, m_pend_d = 0;

    always @(negedge clk) begin
        bit e_if, e_d, e_rd, e_wr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        #1;
        if (!reset) begin
            {e_if, e_d, e_rd, e_wr} = '0;
            e_addr = '0; e_wdata = '0;
            m_streak = 0; m_last_addr = '0; m_last_wdata = '0;
            m_pend_if = 0; m_pend_d = 0;
        end else begin
            e_if    = if_req && (!d_req || m_streak == MS);
            e_d     = d_req && !e_if;
            e_addr  = e_if ? if_addr : e_d ? d_addr : m_last_addr;
            e_wdata = e_d ? d_wdata : m_last_wdata;
            e_rd    = e_if || (e_d && !d_we);
            e_wr    = e_d && d_we;
        end
        check("if_gnt", DW'(if_gnt), DW'(e_if));
        check("d_gnt", DW'(d_gnt), DW'(e_d));
        check("read_mem", DW'(read_mem), DW'(e_rd));
        check("write_mem", DW'(write_mem), DW'(e_wr));
        check("mem_addr", DW'(mem_addr), DW'(e_addr));
        check("mem_wdata", mem_wdata, e_wdata);
        check("if_rvalid", DW'(if_rvalid), DW'(m_pend_if));
        check("d_rvalid", DW'(d_rvalid), DW'(m_pend_d));
        if (m_pend_if) check("if_rdata", if_rdata, m_pend_data);
        if (m_pend_d) check("d_rdata", d_rdata, m_pend_data);
        if (reset) begin
            m_pend_if   = e_if;
            m_pend_d    = e_d && !d_we;
            m_pend_data = mdl_mem[e_addr];
            if (e_wr) mdl_mem[e_addr] = e_wdata;
            m_last_addr  = e_addr;
            m_last_wdata = e_wdata;
            m_streak = (if_req && e_d) ? m_streak + 1 : 0;
            if (m_streak > MS) begin
                errors++;
                $display("FAIL streak: got %0d expected <= %0d", m_streak, MS);
            end
        end
    end

    task automatic drive(input bit ir, input logic [AW-1:0] ia, input bit dr, input bit we,
                         input logic [AW-1:0] da, input logic [DW-1:0] wd);
        @(posedge clk); #1;
        if_req = ir; if_addr = ia; d_req = dr; d_we = we; d_addr = da; d_wdata = wd;
    endtask

    task automatic at_sample;
        @(negedge clk); #2;
    endtask

    logic [9:0] g_pat;

    initial begin
        for (int i = 0; i < 2**AW; i++) begin
            mem[i] = 32'hA5000000 | DW'(i);
            mdl_mem[i] = 32'hA5000000 | DW'(i);
        end
        at_sample;
        check("reset if_gnt", DW'(if_gnt), 0);
        check("reset mem_addr", DW'(mem_addr), 0);
        @(posedge clk); #1 reset = 1;
        // Fetch only
        drive(1, 11'h005, 0, 0, 0, 0);
        at_sample;
        check("fetch gnt", DW'(if_gnt), 1);
        check("fetch read_mem", DW'(read_mem), 1);
        check("fetch addr", DW'(mem_addr), 11'h005);
        drive(0, 0, 0, 0, 0, 0);
        at_sample;
        check("fetch rvalid", DW'(if_rvalid), 1);
        check("fetch rdata", if_rdata, 32'hA5000005);
        // Contention: data wins
        drive(1, 11'h006, 1, 0, 11'h100, 0);
        at_sample;
        check("cont d_gnt", DW'(d_gnt), 1);
        check("cont if_gnt", DW'(if_gnt), 0);
        check("cont addr", DW'(mem_addr), 11'h100);
        drive(1, 11'h006, 0, 0, 0, 0);
        at_sample;
        check("cont d_rvalid", DW'(d_rvalid), 1);
        check("cont if_rvalid", DW'(if_rvalid), 0);
        check("cont d_rdata", d_rdata, 32'hA5000100);
        check("cont fetch now", DW'(if_gnt), 1);
        // Store
        drive(0, 0, 1, 1, 11'h7FF, 32'hDEADBEEF);
        at_sample;
        check("st write_mem", DW'(write_mem), 1);
        check("st read_mem", DW'(read_mem), 0);
        check("st wdata", mem_wdata, 32'hDEADBEEF);
        check("st addr", DW'(mem_addr), 11'h7FF);
        drive(0, 0, 0, 0, 0, 0);
        at_sample;
        check("st no rvalid", DW'(d_rvalid), 0);
        check("idle hold addr", DW'(mem_addr), 11'h7FF);
        check("idle hold wdata", mem_wdata, 32'hDEADBEEF);
        drive(0, 0, 1, 0, 11'h7FF, 0);
        drive(0, 0, 0, 0, 0, 0);
        at_sample;
        check("ld back", d_rdata, 32'hDEADBEEF);
        // Starvation bound: D D D D F D D D D F
        for (int i = 0; i < 10; i++) begin
            drive(1, 11'h010, 1, 0, 11'h200 + 11'(i), 0);
            at_sample;
            g_pat[i] = if_gnt;
        end
        check("starve pattern", DW'(g_pat), 32'h210);
        // Idle
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            at_sample;
            check("idle enables", DW'({read_mem, write_mem}), 0);
        end
        // Reset mid-read
        drive(1, 11'h033, 0, 0, 0, 0);
        at_sample;
        check("rst fetch gnt", DW'(if_gnt), 1);
        @(posedge clk); #2 reset = 0;
        at_sample;
        check("in rst gnt", DW'(if_gnt), 0);
        check("in rst rvalid", DW'(if_rvalid), 0);
        @(posedge clk); @(posedge clk); #1 reset = 1;
        if_req = 0;
        at_sample;
        check("post rst rvalid", DW'(if_rvalid), 0);
        // Mixed traffic: store then fetch/load interleave
        drive(1, 11'h040, 1, 1, 11'h040, 32'h12345678);
        drive(1, 11'h040, 1, 0, 11'h041, 0);
        drive(1, 11'h040, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        at_sample;
        check("mixed fetch data", if_rdata, 32'h12345678);
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
